ic_test_sequencer: RTL and testbench



---
 rtl/ic_test_sequencer.sv | 156 +++++++++++++++
 tb/tb_ic_test_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ic_test_sequencer.sv
// Steps the IC checker through every (tester class, gate) candidate, waits a
// settle interval per candidate, and reports the first candidate that passes.
module ic_test_sequencer #(
  parameter int NUM_GATES     = 6,
  parameter int SETTLE_CYCLES = 100000010,
  parameter int CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       icg,
  input  logic       pass,
  input  logic       fail,
  output logic [2:0] tester,
  output logic [2:0] gate,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       aborted,
  output logic [2:0] found_tester,
  output logic [2:0] found_gate
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       GATE_LAST = 3'(NUM_GATES - 1);
  localparam logic [2:0]       TST_LAST  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tester_q, tester_d;
  logic [2:0]       gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             aborted_q, aborted_d;
  logic [2:0]       found_tester_q, found_tester_d;
  logic [2:0]       found_gate_q, found_gate_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tester_d       = tester_q;
    gate_d         = gate_q;
    found_d        = found_q;
    aborted_d      = aborted_q;
    found_tester_d = found_tester_q;
    found_gate_d   = found_gate_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          found_d = 1'b0;
          if (icg) begin
            aborted_d      = 1'b0;
            found_tester_d = 3'd0;
            found_gate_d   = 3'd0;
            tester_d       = 3'd0;
            gate_d         = 3'd0;
            state_d        = S_APPLY;
          end else begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_APPLY: begin
        if (!icg) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!icg) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (!icg) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (pass && !fail) begin
          found_d        = 1'b1;
          found_tester_d = tester_q;
          found_gate_d   = gate_q;
          state_d        = S_DONE;
        end else if (tester_q == TST_LAST && gate_q == GATE_LAST) begin
          state_d = S_DONE;
        end else begin
          // The NOT class has a single candidate, so it always steps straight on.
          if (tester_q == 3'd0 || gate_q == GATE_LAST) begin
            tester_d = tester_q + 3'd1;
            gate_d   = 3'd0;
          end else begin
            gate_d = gate_q + 3'd1;
          end
          state_d = S_APPLY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they align with it.
    busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      tester_q       <= 3'd0;
      gate_q         <= 3'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      found_q        <= 1'b0;
      aborted_q      <= 1'b0;
      found_tester_q <= 3'd0;
      found_gate_q   <= 3'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tester_q       <= tester_d;
      gate_q         <= gate_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      found_q        <= found_d;
      aborted_q      <= aborted_d;
      found_tester_q <= found_tester_d;
      found_gate_q   <= found_gate_d;
    end
  end

  assign tester       = tester_q;
  assign gate         = gate_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign found        = found_q;
  assign aborted      = aborted_q;
  assign found_tester = found_tester_q;
  assign found_gate   = found_gate_q;

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Bench for ic_test_sequencer: table-driven scans, randomized scans against a
// candidate-list model, and hand sequences for reset and icg-low start.
module tb_ic_test_sequencer;

  localparam int NG   = 6;
  localparam int SC   = 4;
  localparam int PER  = SC + 2;
  localparam int NCAN = 1 + 4 * NG;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       icg = 1'b1;
  logic       pass, fail;
  logic [2:0] tester, gate, found_tester, found_gate;
  logic       busy, done, found, aborted;

  int total = 0;
  int bad = 0;

  // Checker model: 0 = passes only on the target, 1 = always fail,
  // 2 = both high or both low on every candidate.
  int mode = 1;
  int tgt  = 0;

  int cand_t[NCAN];
  int cand_g[NCAN];

  typedef struct {
    int mode;
    int tgt;
    int abort_c;
    int exp_done;
    int exp_found;
    int exp_abort;
  } vec_t;

  ic_test_sequencer #(.NUM_GATES(NG), .SETTLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .icg(icg), .pass(pass), .fail(fail),
    .tester(tester), .gate(gate), .busy(busy), .done(done), .found(found),
    .aborted(aborted), .found_tester(found_tester), .found_gate(found_gate)
  );

  always #5 clk = ~clk;

  always_comb begin
    pass = 1'b0;
    fail = 1'b1;
    if (mode == 0) begin
      pass = (int'(tester) == cand_t[tgt]) && (int'(gate) == cand_g[tgt]);
      fail = !pass;
    end else if (mode == 2) begin
      pass = gate[0];
      fail = gate[0];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timing from the candidate list: the k-th candidate (1-based) ends at
  // 1 + k*PER; icg low seen in busy cycle c ends the scan at c+1.
  function automatic vec_t model(input int md, input int tg, input int ac);
    vec_t v;
    int natural_end;
    natural_end = (md == 0) ? 1 + (tg + 1) * PER : 1 + NCAN * PER;
    v.mode = md; v.tgt = tg; v.abort_c = ac;
    v.exp_done = natural_end; v.exp_found = (md == 0) ? 1 : 0; v.exp_abort = 0;
    if (ac != 0 && ac < natural_end) begin
      v.exp_done = ac + 1; v.exp_found = 0; v.exp_abort = 1;
    end
    return v;
  endfunction

  task automatic run_scan(input vec_t v, input bit noisy);
    bit seen;
    int idx;
    mode = v.mode;
    tgt  = (v.tgt < 0) ? 0 : v.tgt;
    @(posedge clk); #1;
    icg = 1'b1;
    start = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      idx = (c < v.exp_done) ? (c - 1) / PER : (c - 2) / PER;
      if (idx >= NCAN) idx = NCAN - 1;
      chk("busy", busy, (c < v.exp_done) ? 1 : 0);
      chk("done", done, (c == v.exp_done) ? 1 : 0);
      chk("tester", tester, cand_t[idx]);
      chk("gate", gate, cand_g[idx]);
      if (c == 1) begin
        chk("found_cleared", found, 0);
        chk("aborted_cleared", aborted, 0);
      end
      if (done) begin
        seen = 1'b1;
        chk("found", found, v.exp_found);
        chk("aborted", aborted, v.exp_abort);
        if (v.exp_found != 0) begin
          chk("found_tester", found_tester, cand_t[v.tgt]);
          chk("found_gate", found_gate, cand_g[v.tgt]);
        end
      end
      if (c == v.abort_c) icg = 1'b0;
      if (noisy && (c % 7 == 3) && c < v.exp_done) start = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    start = 1'b0;
    icg = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tester"}, tester, 0);
    chk({tag, "_gate"}, gate, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_ftester"}, found_tester, 0);
    chk({tag, "_fgate"}, found_gate, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    n = 0;
    cand_t[0] = 0; cand_g[0] = 0;
    for (int t = 1; t <= 4; t++)
      for (int g = 0; g < NG; g++) begin
        n++;
        cand_t[n] = t; cand_g[n] = g;
      end

    vecs[0] = '{0, 0, 0, 7, 1, 0};
    vecs[1] = '{0, 10, 0, 67, 1, 0};
    vecs[2] = '{1, -1, 0, 151, 0, 0};
    vecs[3] = '{2, -1, 0, 151, 0, 0};
    vecs[4] = '{0, 24, 21, 22, 0, 1};
    vecs[5] = '{0, 24, 0, 151, 1, 0};
    vecs[6] = '{0, 0, 6, 7, 0, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("reset");

    for (int i = 0; i < 7; i++) run_scan(vecs[i], 1'b0);

    // Start with icg low: immediate abort.
    @(posedge clk); #1;
    icg = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nicg_done", done, 1);
    chk("nicg_aborted", aborted, 1);
    chk("nicg_found", found, 0);
    chk("nicg_busy", busy, 0);
    icg = 1'b1;
    @(posedge clk); #1;
    chk("nicg_done_pulse", done, 0);
    chk("nicg_aborted_held", aborted, 1);

    // Found result first, then reset in the middle of the next scan's SETTLE.
    run_scan(vecs[1], 1'b0);
    @(posedge clk); #1;
    mode = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_idle_busy", busy, 0);

    // Noisy start pulses while busy, then randomized scans.
    run_scan(vecs[1], 1'b1);
    for (int r = 0; r < 12; r++) begin
      int md, tg, ac;
      md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      tg = int'($urandom_range(0, NCAN - 1));
      ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 150)) : 0;
      run_scan(model(md, tg, ac), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
